// File: rtl/ysyx_23060136_mem_load_pkg.sv
// Shared definitions for the MEM-stage load unit: widths, FSM states and
// load funct3 encodings.
package ysyx_23060136_mem_load_pkg;

  localparam int XLEN  = 32;
  localparam int BUS_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // High when a load can never reach the bus: illegal type or misaligned address.
  function automatic logic load_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW:         bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_23060136_mem_load_extract.sv
// Picks the addressed byte/half/word out of an 8-byte-aligned beat and
// sign- or zero-extends it to XLEN.
import ysyx_23060136_mem_load_pkg::*;

module ysyx_23060136_load_extract (
  input  logic [BUS_W-1:0] beat,
  input  logic [2:0]       lane,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  data
);

  // Zero pad so a 16-bit window starting at any lane stays in range.
  logic [BUS_W+7:0] beat_x;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;

  assign beat_x = {8'h00, beat};
  assign byte_v = beat_x[{lane, 3'b000} +: 8];
  assign half_v = beat_x[{lane, 3'b000} +: 16];
  assign word_v = lane[2] ? beat[63:32] : beat[31:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LW:   data = word_v;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060136_mem_load.sv
// MEM-stage load unit: issues one read beat per legal load, extracts the
// result and hands it to WBU; non-loads and faulting loads skip the bus.
import ysyx_23060136_mem_load_pkg::*;

module ysyx_23060136_mem_load (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EXU_MEM_valid,
  output logic             EXU_MEM_ready,
  input  logic             EXU_MEM_is_load,
  input  logic [XLEN-1:0]  EXU_MEM_addr,
  input  logic [2:0]       EXU_MEM_funct3,
  input  logic [4:0]       EXU_MEM_rd,
  output logic [XLEN-1:0]  ARBITER_MEM_raddr,
  output logic [2:0]       ARBITER_MEM_rsize,
  output logic             ARBITER_MEM_raddr_valid,
  input  logic             ARBITER_MEM_raddr_ready,
  input  logic [BUS_W-1:0] ARBITER_MEM_rdata,
  input  logic             ARBITER_MEM_rdata_valid,
  output logic             ARBITER_MEM_rdata_ready,
  output logic             MEM_WBU_valid,
  input  logic             MEM_WBU_ready,
  output logic [4:0]       MEM_WBU_rd,
  output logic [XLEN-1:0]  MEM_WBU_result,
  output logic             MEM_load_error
);

  // Every channel transfers on a clock edge where valid and ready are both
  // high; a valid, once raised, holds its payload until that edge.

  state_t            state, state_nxt;
  logic [XLEN-1:0]   addr_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              is_load_q;
  logic [XLEN-1:0]   result_q;
  logic              err_q;
  logic [XLEN-1:0]   ext_data;
  logic              accept;
  logic              in_bad;

  assign accept = (state == ST_IDLE) && EXU_MEM_valid;
  assign in_bad = EXU_MEM_is_load && load_bad(EXU_MEM_funct3, EXU_MEM_addr[1:0]);

  ysyx_23060136_load_extract u_extract (
    .beat   (ARBITER_MEM_rdata),
    .lane   (addr_q[2:0]),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q    <= EXU_MEM_addr;
        funct3_q  <= EXU_MEM_funct3;
        rd_q      <= EXU_MEM_rd;
        is_load_q <= EXU_MEM_is_load;
        err_q     <= in_bad;
        result_q  <= EXU_MEM_is_load ? '0 : EXU_MEM_addr;
      end
      if ((state == ST_DATA) && ARBITER_MEM_rdata_valid) begin
        result_q <= ext_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (EXU_MEM_valid) state_nxt = (!EXU_MEM_is_load || in_bad) ? ST_OUT : ST_ADDR;
      ST_ADDR: if (ARBITER_MEM_raddr_ready) state_nxt = ST_DATA;
      ST_DATA: if (ARBITER_MEM_rdata_valid) state_nxt = ST_OUT;
      ST_OUT:  if (MEM_WBU_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign EXU_MEM_ready           = (state == ST_IDLE);
  assign ARBITER_MEM_raddr_valid = (state == ST_ADDR) && is_load_q;
  assign ARBITER_MEM_raddr       = addr_q;
  assign ARBITER_MEM_rsize       = {1'b0, funct3_q[1:0]};
  assign ARBITER_MEM_rdata_ready = (state == ST_DATA);
  assign MEM_WBU_valid           = (state == ST_OUT);
  assign MEM_WBU_rd              = rd_q;
  assign MEM_WBU_result          = result_q;
  assign MEM_load_error          = err_q;

endmodule

// File: tb/tb_ysyx_23060136_mem_load.sv
// Bench for ysyx_23060136_mem_load: directed vector table, reset corner and
// random loads checked against an arithmetic reference model.
module tb_ysyx_23060136_mem_load;

  logic        clk;
  logic        rst_n;
  logic        EXU_MEM_valid;
  logic        EXU_MEM_ready;
  logic        EXU_MEM_is_load;
  logic [31:0] EXU_MEM_addr;
  logic [2:0]  EXU_MEM_funct3;
  logic [4:0]  EXU_MEM_rd;
  logic [31:0] ARBITER_MEM_raddr;
  logic [2:0]  ARBITER_MEM_rsize;
  logic        ARBITER_MEM_raddr_valid;
  logic        ARBITER_MEM_raddr_ready;
  logic [63:0] ARBITER_MEM_rdata;
  logic        ARBITER_MEM_rdata_valid;
  logic        ARBITER_MEM_rdata_ready;
  logic        MEM_WBU_valid;
  logic        MEM_WBU_ready;
  logic [4:0]  MEM_WBU_rd;
  logic [31:0] MEM_WBU_result;
  logic        MEM_load_error;

  int errors = 0;
  int checks = 0;
  int n_raddr = 0;
  int n_rdata = 0;
  int n_wbu = 0;

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [63:0] beat;
    logic [31:0] exp_res;
    logic        exp_err;
    logic        exp_bus;
    int          d_ra;
    int          d_rd;
    int          d_wb;
  } vec_t;

  vec_t vecs[15];

  ysyx_23060136_mem_load dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .EXU_MEM_valid           (EXU_MEM_valid),
    .EXU_MEM_ready           (EXU_MEM_ready),
    .EXU_MEM_is_load         (EXU_MEM_is_load),
    .EXU_MEM_addr            (EXU_MEM_addr),
    .EXU_MEM_funct3          (EXU_MEM_funct3),
    .EXU_MEM_rd              (EXU_MEM_rd),
    .ARBITER_MEM_raddr       (ARBITER_MEM_raddr),
    .ARBITER_MEM_rsize       (ARBITER_MEM_rsize),
    .ARBITER_MEM_raddr_valid (ARBITER_MEM_raddr_valid),
    .ARBITER_MEM_raddr_ready (ARBITER_MEM_raddr_ready),
    .ARBITER_MEM_rdata       (ARBITER_MEM_rdata),
    .ARBITER_MEM_rdata_valid (ARBITER_MEM_rdata_valid),
    .ARBITER_MEM_rdata_ready (ARBITER_MEM_rdata_ready),
    .MEM_WBU_valid           (MEM_WBU_valid),
    .MEM_WBU_ready           (MEM_WBU_ready),
    .MEM_WBU_rd              (MEM_WBU_rd),
    .MEM_WBU_result          (MEM_WBU_result),
    .MEM_load_error          (MEM_load_error)
  );

  // Clock and handshake monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ARBITER_MEM_raddr_valid && ARBITER_MEM_raddr_ready) n_raddr <= n_raddr + 1;
    if (ARBITER_MEM_rdata_valid && ARBITER_MEM_rdata_ready) n_rdata <= n_rdata + 1;
    if (MEM_WBU_valid && MEM_WBU_ready) n_wbu <= n_wbu + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: straight from the load rules, in plain arithmetic.
  task automatic ref_load(input logic is_load, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] beat, output logic [31:0] res,
                          output logic err, output logic bus);
    int n;
    bit sgn;
    longint unsigned v;
    res = 0; err = 0; bus = 0;
    if (!is_load) begin
      res = addr;
      return;
    end
    case (f3)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: begin n = 4; sgn = 1; end
      3'd4: begin n = 1; sgn = 0; end
      3'd5: begin n = 2; sgn = 0; end
      default: begin n = 0; sgn = 0; end
    endcase
    if (n == 0 || (addr % n) != 0) begin
      err = 1;
      return;
    end
    bus = 1;
    v = (longint'(beat) >> (8 * (addr % 8))) % (64'd1 << (8 * n));
    if (sgn && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    res = v[31:0];
  endtask

  // Drivers
  task automatic exu_noise();
    EXU_MEM_valid   = 1'($urandom_range(0, 1));
    EXU_MEM_is_load = 1'($urandom_range(0, 1));
    EXU_MEM_addr    = $urandom;
    EXU_MEM_funct3  = 3'($urandom_range(0, 7));
    EXU_MEM_rd      = 5'($urandom_range(0, 31));
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int b_ra, b_rd, b_wb;
    logic [2:0] exp_rsize;
    exp_rsize = {1'b0, v.f3[1:0]};
    @(negedge clk);
    b_ra = n_raddr; b_rd = n_rdata; b_wb = n_wbu;
    chk({tag, " exu_ready_idle"}, EXU_MEM_ready, 1);
    EXU_MEM_valid   = 1'b1;
    EXU_MEM_is_load = v.is_load;
    EXU_MEM_addr    = v.addr;
    EXU_MEM_funct3  = v.f3;
    EXU_MEM_rd      = v.rd;
    @(posedge clk); #1;
    exu_noise();
    @(negedge clk);
    chk({tag, " exu_ready_busy"}, EXU_MEM_ready, 0);
    if (v.exp_bus) begin
      chk({tag, " raddr_valid"}, ARBITER_MEM_raddr_valid, 1);
      chk({tag, " raddr"}, ARBITER_MEM_raddr, v.addr);
      chk({tag, " rsize"}, ARBITER_MEM_rsize, exp_rsize);
      chk({tag, " wbu_valid_early"}, MEM_WBU_valid, 0);
      for (int i = 0; i < v.d_ra; i++) begin
        ARBITER_MEM_rdata_valid = 1'($urandom_range(0, 1));
        ARBITER_MEM_rdata       = {$urandom, $urandom};
        @(negedge clk);
        chk({tag, " raddr_hold"}, {ARBITER_MEM_raddr_valid, ARBITER_MEM_rsize, ARBITER_MEM_raddr},
            {1'b1, exp_rsize, v.addr});
      end
      ARBITER_MEM_rdata_valid = 1'b0;
      ARBITER_MEM_raddr_ready = 1'b1;
      @(posedge clk); #1;
      ARBITER_MEM_raddr_ready = 1'b0;
      @(negedge clk);
      chk({tag, " raddr_drop"}, ARBITER_MEM_raddr_valid, 0);
      chk({tag, " rdata_ready"}, ARBITER_MEM_rdata_ready, 1);
      for (int i = 0; i < v.d_rd; i++) begin
        @(negedge clk);
        chk({tag, " rdata_wait"}, {ARBITER_MEM_rdata_ready, MEM_WBU_valid}, 2'b10);
      end
      ARBITER_MEM_rdata_valid = 1'b1;
      ARBITER_MEM_rdata       = v.beat;
      @(posedge clk); #1;
      ARBITER_MEM_rdata_valid = 1'b0;
      ARBITER_MEM_rdata       = {$urandom, $urandom};
      @(negedge clk);
      chk({tag, " rdata_ready_drop"}, ARBITER_MEM_rdata_ready, 0);
    end else begin
      chk({tag, " no_raddr"}, ARBITER_MEM_raddr_valid, 0);
    end
    chk({tag, " wbu_valid"}, MEM_WBU_valid, 1);
    chk({tag, " result"}, MEM_WBU_result, v.exp_res);
    chk({tag, " rd"}, MEM_WBU_rd, v.rd);
    chk({tag, " error"}, MEM_load_error, v.exp_err);
    for (int i = 0; i < v.d_wb; i++) begin
      ARBITER_MEM_rdata_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({tag, " out_hold"}, {MEM_WBU_valid, MEM_load_error, MEM_WBU_rd, MEM_WBU_result},
          {1'b1, v.exp_err, v.rd, v.exp_res});
    end
    MEM_WBU_ready = 1'b1;
    @(posedge clk); #1;
    MEM_WBU_ready = 1'b0;
    EXU_MEM_valid = 1'b0;
    ARBITER_MEM_rdata_valid = 1'b0;
    @(negedge clk);
    chk({tag, " wbu_drop"}, MEM_WBU_valid, 0);
    chk({tag, " exu_ready_back"}, EXU_MEM_ready, 1);
    chk({tag, " n_raddr"}, 64'(n_raddr - b_ra), v.exp_bus ? 64'd1 : 64'd0);
    chk({tag, " n_rdata"}, 64'(n_rdata - b_rd), v.exp_bus ? 64'd1 : 64'd0);
    chk({tag, " n_wbu"}, 64'(n_wbu - b_wb), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " exu_ready"}, EXU_MEM_ready, 1);
    chk({tag, " zeros"}, {ARBITER_MEM_raddr_valid, ARBITER_MEM_rdata_ready, MEM_WBU_valid,
                          MEM_load_error, ARBITER_MEM_rsize, MEM_WBU_rd}, 0);
    chk({tag, " raddr"}, ARBITER_MEM_raddr, 0);
    chk({tag, " result"}, MEM_WBU_result, 0);
  endtask

  initial begin
    vec_t rv;
    logic [31:0] r_res;
    logic r_err, r_bus;

    vecs[0]  = '{1'b1, 3'b000, 32'h8000_0003, 5'd5,  64'h1122_3344_8877_6655, 32'hFFFF_FF88, 1'b0, 1'b1, 0, 0, 0};
    vecs[1]  = '{1'b1, 3'b101, 32'h8000_0006, 5'd6,  64'hABCD_0000_0000_0000, 32'h0000_ABCD, 1'b0, 1'b1, 1, 1, 0};
    vecs[2]  = '{1'b1, 3'b010, 32'h8000_0002, 5'd8,  64'h1111_2222_3333_4444, 32'h0,         1'b1, 1'b0, 0, 0, 0};
    vecs[3]  = '{1'b1, 3'b111, 32'h8000_0000, 5'd9,  64'h1111_2222_3333_4444, 32'h0,         1'b1, 1'b0, 0, 0, 0};
    vecs[4]  = '{1'b0, 3'b011, 32'h1234_5678, 5'd7,  64'h0,                   32'h1234_5678, 1'b0, 1'b0, 0, 0, 0};
    vecs[5]  = '{1'b1, 3'b001, 32'h8000_0002, 5'd10, 64'h0000_0000_8001_0000, 32'hFFFF_8001, 1'b0, 1'b1, 0, 2, 0};
    vecs[6]  = '{1'b1, 3'b100, 32'h8000_0007, 5'd11, 64'hF000_0000_0000_0000, 32'h0000_00F0, 1'b0, 1'b1, 2, 0, 1};
    vecs[7]  = '{1'b1, 3'b010, 32'h8000_0004, 5'd12, 64'hDEAD_BEEF_0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 0, 0};
    vecs[8]  = '{1'b1, 3'b010, 32'h8000_0000, 5'd13, 64'h0000_0000_CAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b1, 0, 0, 0};
    vecs[9]  = '{1'b1, 3'b000, 32'h8000_0000, 5'd14, 64'h0000_0000_0000_007F, 32'h0000_007F, 1'b0, 1'b1, 0, 0, 0};
    vecs[10] = '{1'b1, 3'b101, 32'h8000_0001, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0,         1'b1, 1'b0, 0, 0, 0};
    vecs[11] = '{1'b1, 3'b011, 32'h8000_0000, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0,         1'b1, 1'b0, 0, 0, 0};
    vecs[12] = '{1'b1, 3'b110, 32'h8000_0004, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0,         1'b1, 1'b0, 0, 0, 2};
    vecs[13] = '{1'b1, 3'b000, 32'h8000_0005, 5'd18, 64'h0000_8000_0000_0000, 32'hFFFF_FF80, 1'b0, 1'b1, 5, 4, 3};
    vecs[14] = '{1'b0, 3'b010, 32'hFFFF_0001, 5'd31, 64'h0,                   32'hFFFF_0001, 1'b0, 1'b0, 0, 0, 3};

    // Reset
    rst_n = 1'b0;
    EXU_MEM_valid = 1'b0; EXU_MEM_is_load = 1'b0; EXU_MEM_addr = '0;
    EXU_MEM_funct3 = '0; EXU_MEM_rd = '0;
    ARBITER_MEM_raddr_ready = 1'b0; ARBITER_MEM_rdata = '0; ARBITER_MEM_rdata_valid = 1'b0;
    MEM_WBU_ready = 1'b0;
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for the data beat, then a fresh load.
    @(negedge clk);
    EXU_MEM_valid = 1'b1; EXU_MEM_is_load = 1'b1; EXU_MEM_addr = 32'h8000_0000;
    EXU_MEM_funct3 = 3'b010; EXU_MEM_rd = 5'd3;
    @(posedge clk); #1;
    EXU_MEM_valid = 1'b0;
    ARBITER_MEM_raddr_ready = 1'b1;
    @(posedge clk); #1;
    ARBITER_MEM_raddr_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid in_data", ARBITER_MEM_rdata_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{1'b1, 3'b010, 32'h8000_0004, 5'd4, 64'h8765_4321_0BAD_F00D, 32'h8765_4321, 1'b0, 1'b1, 0, 1, 0};
    run_txn(rv, "post_rst");

    // Random loads against the reference model
    for (int i = 0; i < 40; i++) begin
      rv.is_load = ($urandom_range(0, 7) != 0);
      rv.f3      = 3'($urandom_range(0, 7));
      rv.addr    = 32'h8000_0000 | 32'($urandom_range(0, 255));
      rv.rd      = 5'($urandom_range(0, 31));
      rv.beat    = {$urandom, $urandom};
      rv.d_ra    = $urandom_range(0, 3);
      rv.d_rd    = $urandom_range(0, 3);
      rv.d_wb    = $urandom_range(0, 3);
      ref_load(rv.is_load, rv.f3, rv.addr, rv.beat, r_res, r_err, r_bus);
      rv.exp_res = r_res;
      rv.exp_err = r_err;
      rv.exp_bus = r_bus;
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
